// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Lane 0 is the most-significant byte of a register.
package regfile_pkg;

  localparam logic [2:0] PPP_A = 3'b000;
  localparam logic [2:0] PPP_U = 3'b001;
  localparam logic [2:0] PPP_D = 3'b010;
  localparam logic [2:0] PPP_E = 3'b011;
  localparam logic [2:0] PPP_O = 3'b100;

  localparam int LANE_W    = 8;
  localparam int MAX_DW    = 1024;
  localparam int MAX_LANES = MAX_DW / LANE_W;

  function automatic int lane_count(input int dw);
    return dw / LANE_W;
  endfunction

  // Byte mask (bit k = lane k) to bit mask; lane 0 lands on the top byte.
  function automatic logic [MAX_DW-1:0] expand_lanes(
    input logic [MAX_LANES-1:0] m,
    input int                   lanes
  );
    logic [MAX_DW-1:0]    r;
    logic [MAX_LANES-1:0] mm;
    r  = '0;
    mm = m;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < lanes && mm[0])
        r = r | ({{(MAX_DW-LANE_W){1'b0}}, 8'hFF}
                 << ((lanes - 1 - k) * LANE_W));
      mm = mm >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_lane_mask.sv
// Decodes a ppp partial-field code into a byte-lane enable mask.
// Bit k of lanes enables lane k (lane 0 = most-significant byte).
module regfile_lane_mask
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]                   ppp,
  output logic [DATA_WIDTH/LANE_W-1:0] lanes
);

  localparam int LANES = lane_count(DATA_WIDTH);

  logic [LANES-1:0] upper;
  logic [LANES-1:0] even;

  for (genvar k = 0; k < LANES; k++) begin : g_pat
    assign upper[k] = (k < LANES / 2);
    assign even[k]  = (k % 2 == 0);
  end

  // Codes 101..111 select no lanes, turning the write into a no-op.
  always_comb begin
    lanes = '0;
    unique case (ppp)
      PPP_A:   lanes = '1;
      PPP_U:   lanes = upper;
      PPP_D:   lanes = ~upper;
      PPP_E:   lanes = even;
      PPP_O:   lanes = ~even;
      default: lanes = '0;
    endcase
  end

endmodule

// File: rtl/regfile_mp_ppp.sv
// Dual-write, multi-read register file with ppp lane writes and forwarding.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_mp_ppp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RD     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wrEn0,
  input  logic [ADDR_WIDTH-1:0]        wrAddr0,
  input  logic [2:0]                   ppp0,
  input  logic [DATA_WIDTH-1:0]        dataIn0,
  input  logic                         wrEn1,
  input  logic [ADDR_WIDTH-1:0]        wrAddr1,
  input  logic [2:0]                   ppp1,
  input  logic [DATA_WIDTH-1:0]        dataIn1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rdAddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] dataOut
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = lane_count(DATA_WIDTH);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (base & ~mask) | (data & mask);
  endfunction

  logic [LANES-1:0]      lanes0, lanes1;
  logic [MAX_DW-1:0]     full0, full1;
  logic [DATA_WIDTH-1:0] bits0, bits1;
  logic                  en0, en1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  regfile_lane_mask #(.DATA_WIDTH(DATA_WIDTH)) u_mask0 (
    .ppp   (ppp0),
    .lanes (lanes0)
  );

  regfile_lane_mask #(.DATA_WIDTH(DATA_WIDTH)) u_mask1 (
    .ppp   (ppp1),
    .lanes (lanes1)
  );

  assign full0 = expand_lanes(MAX_LANES'(lanes0), LANES);
  assign full1 = expand_lanes(MAX_LANES'(lanes1), LANES);
  assign bits0 = full0[DATA_WIDTH-1:0];
  assign bits1 = full1[DATA_WIDTH-1:0];

  if (DATA_WIDTH < MAX_DW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{full0[MAX_DW-1:DATA_WIDTH],
                         full1[MAX_DW-1:DATA_WIDTH]};
  end

  // Reset kills both writes and forwarding; r0 writes vanish when hardwired.
  assign en0 = wrEn0 & ~reset & ~(R0_ZERO && wrAddr0 == '0);
  assign en1 = wrEn1 & ~reset & ~(R0_ZERO && wrAddr1 == '0);

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    if (R0_ZERO && k == 0) begin : g_zero
      assign mem[k] = '0;
    end else begin : g_reg
      logic                  hit0, hit1;
      logic [DATA_WIDTH-1:0] nxt;
      logic [DATA_WIDTH-1:0] q;

      assign hit0 = en0 && (wrAddr0 == ADDR_WIDTH'(k));
      assign hit1 = en1 && (wrAddr1 == ADDR_WIDTH'(k));
      // Port 1 lanes are applied last so they win on overlap.
      assign nxt  = merge(merge(q, dataIn0, hit0 ? bits0 : '0),
                          dataIn1, hit1 ? bits1 : '0);

      // Entry update: clear on reset, otherwise take merged lanes.
      always_ff @(posedge clk) begin
        if (reset)
          q <= '0;
        else if (hit0 || hit1)
          q <= nxt;
      end

      assign mem[k] = q;
    end
  end

  // Port 0 sits in the most-significant field of rdAddr and dataOut.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  h0, h1;

    assign ra = rdAddr[(NUM_RD-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
    assign h0 = en0 && (wrAddr0 == ra);
    assign h1 = en1 && (wrAddr1 == ra);
    assign dataOut[(NUM_RD-1-i)*DATA_WIDTH +: DATA_WIDTH] =
      merge(merge(mem[ra], dataIn0, h0 ? bits0 : '0),
            dataIn1, h1 ? bits1 : '0);
  end

endmodule
